snake_body_store: RTL and testbench

- Storage and read-responder for the snake body segment list.
- Serves indexed reads from the game FSM, which scans segments by driving body_count and reading back snake_body_x/snake_body_y.
- Applies move and grow updates as a multi-cycle shift sequence, one segment per cycle, to match a RAM-style implementation.
- Segment 0 is the head; segment snake_length-1 is the tail.

---
 rtl/snake_body_store_if.sv | 31 +++
 rtl/snake_body_store.sv | 135 +++++++++++++
 tb/tb_snake_body_store.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_body_store_if.sv
// Game-FSM to body-store bundle: update request, indexed read and status.
interface snake_body_store_if #(
    parameter int SNAKE_LENGTH_BIT = 6
);
    logic                        sync_reset;
    logic                        move;
    logic                        grow;
    logic [6:0]                  new_head_x;
    logic [6:0]                  new_head_y;
    logic [SNAKE_LENGTH_BIT-1:0] body_count;
    logic [6:0]                  snake_body_x;
    logic [6:0]                  snake_body_y;
    logic [SNAKE_LENGTH_BIT-1:0] snake_length;
    logic                        busy;
    logic                        move_done;
    logic                        full;

    modport master (
        output sync_reset, move, grow,
        output new_head_x, new_head_y, body_count,
        input  snake_body_x, snake_body_y,
        input  snake_length, busy, move_done, full
    );

    modport slave (
        input  sync_reset, move, grow,
        input  new_head_x, new_head_y, body_count,
        output snake_body_x, snake_body_y,
        output snake_length, busy, move_done, full
    );
endinterface

// File: rtl/snake_body_store.sv
// Snake segment list: registered indexed reads, one-segment-per-cycle shift
// on move/grow, head written last.
module snake_body_store #(
    parameter int SNAKE_LENGTH_BIT = 6,
    parameter int MAX_LENGTH       = 63,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 40,
    parameter int INIT_Y           = 30
) (
    input logic               clock_25,
    input logic               reset,
    snake_body_store_if.slave bus
);
    localparam int W     = SNAKE_LENGTH_BIT;
    localparam int DEPTH = 2 ** W;

    localparam logic [W-1:0] ONE      = W'(1);
    localparam logic [W-1:0] INIT_LEN = W'(INIT_LENGTH);
    localparam logic [W-1:0] MAX_LEN  = W'(MAX_LENGTH);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        INSERT
    } state_t;

    state_t       state_q;
    logic [6:0]   mem_x_q [DEPTH];
    logic [6:0]   mem_y_q [DEPTH];
    logic [W-1:0] idx_q;
    logic [W-1:0] new_len_q;
    logic [W-1:0] len_q;
    logic [6:0]   head_x_q;
    logic [6:0]   head_y_q;
    logic [6:0]   rd_x_q;
    logic [6:0]   rd_y_q;
    logic         busy_q;
    logic         done_q;
    logic         full_q;
    logic [W-1:0] new_len_d;

    // A grow at full length degrades to a plain move.
    always_comb begin
        new_len_d = len_q;
        if (bus.grow && (len_q < MAX_LEN)) begin
            new_len_d = len_q + ONE;
        end
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_X - i) : 7'd0;
                mem_y_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
            end
            state_q   <= IDLE;
            idx_q     <= '0;
            new_len_q <= '0;
            len_q     <= INIT_LEN;
            head_x_q  <= '0;
            head_y_q  <= '0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= (INIT_LEN == MAX_LEN);
        end else if (bus.sync_reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_x_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_X - i) : 7'd0;
                mem_y_q[i] <= (i < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
            end
            state_q   <= IDLE;
            idx_q     <= '0;
            new_len_q <= '0;
            len_q     <= INIT_LEN;
            head_x_q  <= '0;
            head_y_q  <= '0;
            rd_x_q    <= '0;
            rd_y_q    <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            full_q    <= (INIT_LEN == MAX_LEN);
        end else begin
            // Out-of-range indices read back as the off-grid sentinel.
            if (bus.body_count >= len_q) begin
                rd_x_q <= 7'h7F;
                rd_y_q <= 7'h7F;
            end else begin
                rd_x_q <= mem_x_q[bus.body_count];
                rd_y_q <= mem_y_q[bus.body_count];
            end

            unique case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.move) begin
                        head_x_q  <= bus.new_head_x;
                        head_y_q  <= bus.new_head_y;
                        new_len_q <= new_len_d;
                        idx_q     <= new_len_d - ONE;
                        busy_q    <= 1'b1;
                        state_q   <= SHIFT;
                    end
                end
                SHIFT: begin
                    mem_x_q[idx_q] <= mem_x_q[idx_q - ONE];
                    mem_y_q[idx_q] <= mem_y_q[idx_q - ONE];
                    idx_q          <= idx_q - ONE;
                    if (idx_q == ONE) begin
                        state_q <= INSERT;
                    end
                end
                INSERT: begin
                    mem_x_q[0] <= head_x_q;
                    mem_y_q[0] <= head_y_q;
                    len_q      <= new_len_q;
                    full_q     <= (new_len_q == MAX_LEN);
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.snake_body_x = rd_x_q;
    assign bus.snake_body_y = rd_y_q;
    assign bus.snake_length = len_q;
    assign bus.busy         = busy_q;
    assign bus.move_done    = done_q;
    assign bus.full         = full_q;
endmodule

// File: tb/tb_snake_body_store.sv
// Bench for snake_body_store: queue-based body model, random moves/grows,
// reset/sync_reset aborts and length saturation.
module tb_snake_body_store;
    localparam int W     = 6;
    localparam int MAXL  = 63;
    localparam int INITL = 3;
    localparam int IX    = 40;
    localparam int IY    = 30;

    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    logic [13:0] body[$];

    always #5 clk = ~clk;

    snake_body_store_if #(.SNAKE_LENGTH_BIT(W)) bus ();

    snake_body_store #(
        .SNAKE_LENGTH_BIT(W),
        .MAX_LENGTH      (MAXL),
        .INIT_LENGTH     (INITL),
        .INIT_X          (IX),
        .INIT_Y          (IY)
    ) dut (
        .clock_25(clk),
        .reset   (rst),
        .bus     (bus.slave)
    );

    function automatic void model_init();
        body.delete();
        for (int i = 0; i < INITL; i++) begin
            body.push_back({7'(IX - i), 7'(IY)});
        end
    endfunction

    function automatic void model_move(input logic [6:0] x,
                                       input logic [6:0] y,
                                       input logic g);
        bit keep;
        keep = g && (body.size() < MAXL);
        body.push_front({x, y});
        if (!keep) void'(body.pop_back());
    endfunction

    task automatic check_array(input string tag);
        logic [13:0] e;
        for (int i = 0; i < 64; i++) begin
            bus.body_count = 6'(i);
            @(negedge clk);
            e = (i < body.size()) ? body[i] : 14'h3FFF;
            tests++;
            if ({bus.snake_body_x, bus.snake_body_y} !== e) begin
                fails++;
                $display("FAIL read[%s] idx=%0d got (%0d,%0d) want (%0d,%0d)",
                         tag, i, bus.snake_body_x, bus.snake_body_y,
                         e[13:7], e[6:0]);
            end
        end
        bus.body_count = '0;
    endtask

    task automatic check_status(input string tag);
        tests++;
        if (bus.snake_length !== 6'(body.size())) begin
            fails++;
            $display("FAIL length[%s] got %0d want %0d",
                     tag, bus.snake_length, body.size());
        end
        tests++;
        if (bus.full !== (body.size() == MAXL)) begin
            fails++;
            $display("FAIL full[%s] got %0b want %0b",
                     tag, bus.full, body.size() == MAXL);
        end
        tests++;
        if (bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL idle_busy[%s] got %0b want 0", tag, bus.busy);
        end
    endtask

    task automatic do_move(input logic [6:0] x, input logic [6:0] y,
                           input logic g, input string tag);
        int cyc;
        int exp_len;
        @(negedge clk);
        bus.move       = 1'b1;
        bus.grow       = g;
        bus.new_head_x = x;
        bus.new_head_y = y;
        @(negedge clk);
        bus.move = 1'b0;
        bus.grow = 1'b0;
        model_move(x, y, g);
        exp_len = body.size();
        cyc = 0;
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (cyc != exp_len) begin
            fails++;
            $display("FAIL busy_cycles[%s] got %0d want %0d", tag, cyc, exp_len);
        end
        tests++;
        if (bus.move_done !== 1'b1) begin
            fails++;
            $display("FAIL done_pulse[%s] got %0b want 1", tag, bus.move_done);
        end
        check_status(tag);
        @(negedge clk);
        tests++;
        if (bus.move_done !== 1'b0) begin
            fails++;
            $display("FAIL done_width[%s] got %0b want 0", tag, bus.move_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        model_init();
        tests++;
        if ({bus.busy, bus.move_done, bus.full} !== 3'b000) begin
            fails++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.busy, bus.move_done, bus.full});
        end
        tests++;
        if ({bus.snake_body_x, bus.snake_body_y} !== 14'd0) begin
            fails++;
            $display("FAIL reset_read got (%0d,%0d) want (0,0)",
                     bus.snake_body_x, bus.snake_body_y);
        end
        check_status("reset");
        rst = 1'b0;
        @(negedge clk);
        check_array("reset");
    endtask

    task automatic test_move_no_grow();
        do_move(7'd41, 7'd30, 1'b0, "move");
        check_array("move");
    endtask

    task automatic test_move_grow();
        do_move(7'd42, 7'd30, 1'b1, "grow");
        check_array("grow");
        bus.grow = 1'b1;
        repeat (4) @(negedge clk);
        bus.grow = 1'b0;
        check_status("grow_no_move");
    endtask

    task automatic test_move_during_busy();
        int cyc;
        int exp_len;
        int dones;
        @(negedge clk);
        bus.move       = 1'b1;
        bus.grow       = 1'b0;
        bus.new_head_x = 7'd43;
        bus.new_head_y = 7'd31;
        @(negedge clk);
        bus.new_head_x = 7'd10;
        bus.new_head_y = 7'd10;
        bus.grow       = 1'b1;
        cyc = (bus.busy === 1'b1) ? 1 : 0;
        @(negedge clk);
        bus.move = 1'b0;
        bus.grow = 1'b0;
        model_move(7'd43, 7'd31, 1'b0);
        exp_len = body.size();
        while (bus.busy === 1'b1 && cyc < 200) begin
            cyc++;
            @(negedge clk);
        end
        tests++;
        if (cyc != exp_len) begin
            fails++;
            $display("FAIL busy_ignore_cycles got %0d want %0d", cyc, exp_len);
        end
        dones = 0;
        repeat (8) begin
            if (bus.move_done === 1'b1) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones != 1) begin
            fails++;
            $display("FAIL busy_ignore_dones got %0d want 1", dones);
        end
        check_status("busy_ignore");
        check_array("busy_ignore");
    endtask

    task automatic test_sync_reset_mid_shift();
        int dones;
        @(negedge clk);
        bus.move       = 1'b1;
        bus.new_head_x = 7'd5;
        bus.new_head_y = 7'd6;
        @(negedge clk);
        bus.move = 1'b0;
        @(negedge clk);
        bus.sync_reset = 1'b1;
        @(negedge clk);
        bus.sync_reset = 1'b0;
        model_init();
        tests++;
        if ({bus.busy, bus.move_done} !== 2'b00) begin
            fails++;
            $display("FAIL sync_abort got busy/done %b want 00",
                     {bus.busy, bus.move_done});
        end
        check_status("sync_reset");
        dones = 0;
        repeat (6) begin
            if (bus.move_done === 1'b1) dones++;
            @(negedge clk);
        end
        tests++;
        if (dones != 0) begin
            fails++;
            $display("FAIL sync_no_done got %0d want 0", dones);
        end
        check_array("sync_reset");
    endtask

    task automatic test_async_reset_mid_insert();
        @(negedge clk);
        bus.move       = 1'b1;
        bus.grow       = 1'b1;
        bus.new_head_x = 7'd99;
        bus.new_head_y = 7'd98;
        @(negedge clk);
        bus.move = 1'b0;
        bus.grow = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        model_init();
        tests++;
        if ({bus.busy, bus.move_done} !== 2'b00) begin
            fails++;
            $display("FAIL async_abort got busy/done %b want 00",
                     {bus.busy, bus.move_done});
        end
        check_status("async_reset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_array("async_reset");
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            do_move(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    1'($urandom_range(0, 1)), "random");
            check_array("random");
        end
    endtask

    task automatic test_back_to_back();
        do_move(7'd1, 7'd2, 1'b1, "b2b_a");
        do_move(7'd3, 7'd4, 1'b0, "b2b_b");
        check_array("b2b");
    endtask

    task automatic test_saturation();
        while (body.size() < MAXL) begin
            do_move(7'($urandom_range(0, 127)), 7'($urandom_range(0, 127)),
                    1'b1, "fill");
        end
        check_array("full");
        do_move(7'd77, 7'd66, 1'b1, "grow_at_full");
        check_array("grow_at_full");
    endtask

    initial begin
        rst            = 1'b1;
        bus.sync_reset = 1'b0;
        bus.move       = 1'b0;
        bus.grow       = 1'b0;
        bus.new_head_x = '0;
        bus.new_head_y = '0;
        bus.body_count = '0;
        test_reset();
        test_move_no_grow();
        test_move_grow();
        test_move_during_busy();
        test_sync_reset_mid_shift();
        test_async_reset_mid_insert();
        test_random();
        test_back_to_back();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
